// File: rtl/clk_mon_pkg.sv
// rtl/clk_mon_pkg.sv - shared state type and default constants for the fabric clock lock monitor
package clk_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } clk_mon_state_e;

    // 100 MHz fabric clock against the 32.768 kHz reference
    localparam int EXP_COUNT_DEF = 3052;
    localparam int TOL_DEF       = 8;
    localparam int LOCK_CNT_DEF  = 4;
    localparam int CNT_W_DEF     = 16;

endpackage

// File: rtl/clk_mon_sync.sv
// rtl/clk_mon_sync.sv - two-flop synchronizer for the slow reference plus rising-edge detect
module clk_mon_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic hist_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~hist_q;

endmodule

// File: rtl/fab_clk_lock_monitor.sv
// rtl/fab_clk_lock_monitor.sv - measures FAB_CLK cycles per REF_CLK period and reports lock/fault
// Define CLK_MON_STICKY_FAULT_EN to hold FAULT until RESET or ENABLE=0.
module fab_clk_lock_monitor
    import clk_mon_pkg::*;
#(
    parameter int EXP_COUNT = EXP_COUNT_DEF,
    parameter int TOL       = TOL_DEF,
    parameter int LOCK_CNT  = LOCK_CNT_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             FAB_CLK,
    input  logic             RESET,
    input  logic             REF_CLK,
    input  logic             ENABLE,
    output logic             FAB_LOCK,
    output logic             FAULT,
    output logic             MEAS_VALID,
    output logic [CNT_W-1:0] MEAS_COUNT
);

    localparam int                 RUN_W    = $clog2(LOCK_CNT + 1);
    localparam logic [RUN_W-1:0]   RUN_MAX  = RUN_W'(LOCK_CNT);
    localparam logic [CNT_W:0]     TMO_LAST = (CNT_W+1)'(2 * EXP_COUNT - 1);
    localparam logic signed [CNT_W:0] EXP_S = (CNT_W+1)'(EXP_COUNT);
    localparam logic signed [CNT_W:0] TOL_S = (CNT_W+1)'(TOL);

    clk_mon_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             lock_q, lock_d;
    logic             fault_q, fault_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] meas_q, meas_d;

    logic                    ref_rise;
    logic [CNT_W-1:0]        meas_new;
    logic signed [CNT_W:0]   meas_diff;
    logic                    meas_good;
    logic [RUN_W-1:0]        run_inc;
    logic                    timeout;

    clk_mon_sync u_sync (
        .clk_i   (FAB_CLK),
        .rst_i   (RESET),
        .async_i (REF_CLK),
        .rise_o  (ref_rise)
    );

    // Count of the period just closed includes the edge cycle itself.
    assign meas_new  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign meas_diff = $signed({1'b0, meas_new}) - EXP_S;
    assign meas_good = (meas_diff >= -TOL_S) && (meas_diff <= TOL_S);
    assign run_inc   = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
    assign timeout   = ({1'b0, cnt_q} == TMO_LAST);

    always_ff @(posedge FAB_CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            run_q   <= '0;
            lock_q  <= 1'b0;
            fault_q <= 1'b0;
            valid_q <= 1'b0;
            meas_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            lock_q  <= lock_d;
            fault_q <= fault_d;
            valid_q <= valid_d;
            meas_q  <= meas_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        lock_d  = lock_q;
        fault_d = fault_q;
        valid_d = 1'b0;
        meas_d  = meas_q;

        if (!ENABLE) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            run_d   = '0;
            lock_d  = 1'b0;
            fault_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARM;
                end
                ST_ARM: begin
                    if (ref_rise) begin
                        state_d = ST_MEASURE;
                        cnt_d   = '0;
                    end
                end
                ST_MEASURE: begin
                    // A reference edge always beats a coincident timeout.
                    if (ref_rise) begin
                        cnt_d   = '0;
                        meas_d  = meas_new;
                        valid_d = 1'b1;
                        if (meas_good) begin
                            run_d = run_inc;
                            if (run_inc == RUN_MAX) begin
                                lock_d = 1'b1;
                            end
`ifdef CLK_MON_STICKY_FAULT_EN
                            fault_d = fault_q;
`else
                            fault_d = 1'b0;
`endif
                        end else begin
                            run_d  = '0;
                            lock_d = 1'b0;
                        end
                    end else if (timeout) begin
                        state_d = ST_ARM;
                        cnt_d   = '0;
                        run_d   = '0;
                        lock_d  = 1'b0;
                        fault_d = 1'b1;
                    end else if (!(&cnt_q)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign FAB_LOCK   = lock_q;
    assign FAULT      = fault_q;
    assign MEAS_VALID = valid_q;
    assign MEAS_COUNT = meas_q;

endmodule

// File: tb/tb_fab_clk_lock_monitor.sv
// tb/tb_fab_clk_lock_monitor.sv - randomized self-checking bench with a timestamp-based reference model
module tb_fab_clk_lock_monitor;

    localparam int EXP = 3052;
    localparam int TOL = 8;
    localparam int LCK = 4;
    localparam int W   = 16;
    localparam int TMO = 2 * EXP;
`ifdef CLK_MON_STICKY_FAULT_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic         FAB_CLK = 1'b0;
    logic         RESET;
    logic         REF_CLK;
    logic         ENABLE;
    logic         FAB_LOCK;
    logic         FAULT;
    logic         MEAS_VALID;
    logic [W-1:0] MEAS_COUNT;

    always #5 FAB_CLK = ~FAB_CLK;

    fab_clk_lock_monitor #(
        .EXP_COUNT (EXP),
        .TOL       (TOL),
        .LOCK_CNT  (LCK),
        .CNT_W     (W)
    ) dut (
        .FAB_CLK    (FAB_CLK),
        .RESET      (RESET),
        .REF_CLK    (REF_CLK),
        .ENABLE     (ENABLE),
        .FAB_LOCK   (FAB_LOCK),
        .FAULT      (FAULT),
        .MEAS_VALID (MEAS_VALID),
        .MEAS_COUNT (MEAS_COUNT)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Input values as seen by the design at each rising edge
    logic s_en, s_rst, s_ref;
    always @(posedge FAB_CLK) begin
        s_en  = ENABLE;
        s_rst = RESET;
        s_ref = REF_CLK;
    end

    // Reference model: edges are timestamped; a period is the distance between two counted edges
    bit           m_idle = 1'b1;
    bit           m_armed, m_lock, m_fault, m_valid;
    int           m_run, m_last, period;
    logic [W-1:0] m_meas;
    bit           r1, r2, r3, rise;
    int           cyc = 0;
    int           exp_nvalid = 0;

    logic [W+2:0] dut_v, mod_v, prev_dut, prev_mod;
    bit           first = 1'b1;
    int           n_valid = 0;
    int           last_valid_cyc = -1;
    int           fault_cyc = -1;
    int           lock_rise_nvalid = -1;
    logic [W-1:0] last_meas = '0;
    logic         last_lock = 1'b0;
    logic         prev_lock = 1'b0;
    logic         prev_fault = 1'b0;

    always @(negedge FAB_CLK) begin
        cyc++;
        m_valid = 1'b0;
        if (RESET || s_rst) begin
            m_idle = 1'b1; m_armed = 1'b0; m_lock = 1'b0; m_fault = 1'b0;
            m_run = 0; m_meas = '0;
            r1 = 1'b0; r2 = 1'b0; r3 = 1'b0;
        end else begin
            // an edge driven at cycle t is acted on three rising edges later
            rise = r2 && !r3;
            if (!s_en) begin
                m_idle = 1'b1; m_armed = 1'b0; m_lock = 1'b0; m_fault = 1'b0; m_run = 0;
            end else if (m_idle) begin
                m_idle = 1'b0;
            end else if (rise) begin
                if (!m_armed) begin
                    m_armed = 1'b1;
                    m_last  = cyc;
                end else begin
                    period  = cyc - m_last;
                    m_last  = cyc;
                    m_valid = 1'b1;
                    m_meas  = W'(period);
                    exp_nvalid++;
                    if (period >= EXP - TOL && period <= EXP + TOL) begin
                        if (m_run < LCK) m_run++;
                        if (m_run == LCK) m_lock = 1'b1;
                        if (!STICKY) m_fault = 1'b0;
                    end else begin
                        m_run  = 0;
                        m_lock = 1'b0;
                    end
                end
            end else if (m_armed && (cyc - m_last == TMO)) begin
                m_fault = 1'b1; m_lock = 1'b0; m_run = 0; m_armed = 1'b0;
            end
            r3 = r2; r2 = r1; r1 = s_ref;
        end

        dut_v = {MEAS_VALID, FAB_LOCK, FAULT, MEAS_COUNT};
        mod_v = {m_valid, m_lock, m_fault, m_meas};
        if (first || dut_v !== prev_dut || mod_v !== prev_mod)
            check("status{valid,lock,fault,count}", dut_v, mod_v);
        prev_dut = dut_v;
        prev_mod = mod_v;
        first    = 1'b0;

        if (MEAS_VALID === 1'b1) begin
            n_valid++;
            last_valid_cyc = cyc;
            last_meas      = MEAS_COUNT;
            last_lock      = FAB_LOCK;
        end
        if (FAB_LOCK === 1'b1 && !prev_lock && lock_rise_nvalid < 0) lock_rise_nvalid = n_valid;
        if (FAULT === 1'b1 && !prev_fault) fault_cyc = cyc;
        prev_lock  = FAB_LOCK;
        prev_fault = FAULT;
    end

    task automatic tick();
        @(posedge FAB_CLK);
        #1;
    endtask

    task automatic ref_period(input int p);
        for (int i = 0; i < p; i++) begin
            tick();
            REF_CLK = (i < p / 2);
        end
    endtask

    function automatic int good_p();
        return EXP - TOL + int'($urandom_range(0, 2 * TOL));
    endfunction

    int p;
    int v0;

    initial begin
        RESET = 1'b1; ENABLE = 1'b0; REF_CLK = 1'b0;
        repeat (4) tick();
        check("reset_lock", FAB_LOCK, 0);
        check("reset_fault", FAULT, 0);
        check("reset_valid", MEAS_VALID, 0);
        check("reset_count", MEAS_COUNT, 0);
        RESET = 1'b0; ENABLE = 1'b1;
        repeat (10) tick();

        // nominal reference: arm edge then four good periods
        repeat (5) ref_period(EXP);
        check("valids_before_lock", n_valid, 4);
        check("lock_at_4th_valid", lock_rise_nvalid, 4);
        check("lock_nominal", FAB_LOCK, 1);
        check("meas_nominal", last_meas, EXP);

        // tolerance boundary
        ref_period(EXP + TOL);
        ref_period(EXP + TOL + 1);
        check("meas_upper_bound", last_meas, EXP + TOL);
        check("lock_kept_upper_bound", last_lock, 1);
        ref_period(int'($urandom_range(EXP - 3 * TOL, EXP + 3 * TOL)));
        check("meas_over_bound", last_meas, EXP + TOL + 1);
        check("lock_drop_over_bound", last_lock, 0);
        repeat (5) ref_period(good_p());
        check("locked_before_stop", FAB_LOCK, 1);

        // reference stops
        v0 = n_valid;
        repeat (TMO + 200) begin
            tick();
            REF_CLK = 1'b0;
        end
        check("fault_set", FAULT, 1);
        check("timeout_distance", fault_cyc - last_valid_cyc, TMO);
        check("lock_at_fault", FAB_LOCK, 0);
        check("no_valid_on_timeout", n_valid, v0);

        // reference restarts
        repeat (5) ref_period(good_p());
        check("relock", FAB_LOCK, 1);
        check("fault_after_relock", FAULT, STICKY);

        // reset pulse mid-period while locked
        p = good_p();
        for (int i = 0; i < p; i++) begin
            tick();
            REF_CLK = (i < p / 2);
            if (i == 2000) begin
                check("locked_before_reset", FAB_LOCK, 1);
                RESET = 1'b1;
                #1;
                check("rst_async_lock", FAB_LOCK, 0);
                check("rst_async_fault", FAULT, 0);
                check("rst_async_count", MEAS_COUNT, 0);
            end
            if (i == 2004) RESET = 1'b0;
        end
        v0 = n_valid;
        ref_period(good_p());
        check("no_valid_first_edge_after_reset", n_valid, v0);
        ref_period(good_p());
        check("valid_second_edge_after_reset", n_valid, v0 + 1);

        // ENABLE drops in the same cycle the edge is acted on
        v0 = n_valid;
        p  = good_p();
        for (int i = 0; i < p; i++) begin
            tick();
            REF_CLK = (i < p / 2);
            if (i == 2) ENABLE = 1'b0;
            if (i == 3) begin
                check("disable_no_valid", MEAS_VALID, 0);
                check("disable_lock", FAB_LOCK, 0);
            end
        end
        check("disable_valid_count", n_valid, v0);
        ENABLE = 1'b1;
        repeat (20) tick();
        check("valid_total", n_valid, exp_nvalid);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
